// File: rtl/signed_sat_accumulator.sv
// Streaming signed accumulator: sums frames of COUNT samples, clamping to the
// WIDTH-bit two's-complement range, and reports a per-frame saturation flag.
module signed_sat_accumulator #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data,
  output logic             down_sat
);

  localparam int unsigned CW  = $clog2(COUNT + 1);
  localparam int unsigned MSB = WIDTH - 1;
  localparam logic [CW-1:0]    LAST    = CW'(COUNT - 1);
  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {ACC, OUT} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             sat_flag;

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] next_c;
  logic             ovf_c;
  logic             accept_c;

  // Wrapped add; overflow only when both operands share a sign the result lost.
  always_comb begin
    sum_c  = acc + up_data;
    ovf_c  = (acc[MSB] == up_data[MSB]) && (sum_c[MSB] != acc[MSB]);
    next_c = sum_c;
    if (ovf_c) begin
      next_c = acc[MSB] ? NEG_MIN : POS_MAX;
    end
  end

  assign up_ready   = (state == ACC);
  assign down_valid = (state == OUT);
  assign accept_c   = up_valid && up_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      sat_flag  <= 1'b0;
      down_data <= '0;
      down_sat  <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept_c) begin
            acc      <= next_c;
            sat_flag <= sat_flag | ovf_c;
            if (cnt == LAST) begin
              cnt       <= '0;
              state     <= OUT;
              down_data <= next_c;
              down_sat  <= sat_flag | ovf_c;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        OUT: begin
          if (down_ready) begin
            acc      <= '0;
            sat_flag <= 1'b0;
            state    <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Directed bench for signed_sat_accumulator (WIDTH=4, COUNT=4); inputs are
// driven and outputs sampled on the falling edge.
module tb_signed_sat_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid;
  logic       up_ready;
  logic [3:0] up_data;
  logic       down_valid;
  logic       down_ready;
  logic [3:0] down_data;
  logic       down_sat;

  int total = 0;
  int bad   = 0;

  signed_sat_accumulator #(.WIDTH(4), .COUNT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_data   (up_data),
    .down_valid(down_valid),
    .down_ready(down_ready),
    .down_data (down_data),
    .down_sat  (down_sat)
  );

  always #5 clk = ~clk;

  // Present one sample from a falling edge and hold it until it is consumed.
  task automatic beat(input logic [3:0] d);
    int waited;
    @(negedge clk);
    up_valid = 1'b1;
    up_data  = d;
    waited   = 0;
    while (!up_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!up_ready) begin
      $display("FAIL beat_timeout: up_ready=%0b required 1", up_ready);
      bad++;
      total++;
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    up_valid = 1'b0;
    up_data  = 4'h7;
  endtask

  // Ends on the falling edge after the last beat with up_valid dropped.
  task automatic frame(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    beat(a);
    beat(b);
    beat(c);
    beat(d);
    idle();
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    up_valid   = 1'b0;
    up_data    = 4'h0;
    down_ready = 1'b1;
    repeat (2) @(negedge clk);
    if (up_ready !== 1'b1) begin $display("FAIL rst_up_ready: got %0b want 1", up_ready); bad++; end
    total++;
    if (down_valid !== 1'b0) begin $display("FAIL rst_down_valid: got %0b want 0", down_valid); bad++; end
    total++;
    if (down_data !== 4'h0) begin $display("FAIL rst_down_data: got %h want 0", down_data); bad++; end
    total++;
    if (down_sat !== 1'b0) begin $display("FAIL rst_down_sat: got %0b want 0", down_sat); bad++; end
    total++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    frame(4'h1, 4'h2, 4'h3, 4'hF);
    if (down_valid !== 1'b1) begin $display("FAIL basic_valid: got %0b want 1", down_valid); bad++; end
    total++;
    if (up_ready !== 1'b0) begin $display("FAIL basic_up_ready_low: got %0b want 0", up_ready); bad++; end
    total++;
    if (down_data !== 4'h5) begin $display("FAIL basic_data: got %h want 5", down_data); bad++; end
    total++;
    if (down_sat !== 1'b0) begin $display("FAIL basic_sat: got %0b want 0", down_sat); bad++; end
    total++;
    @(negedge clk);
    if (up_ready !== 1'b1) begin $display("FAIL basic_up_ready_back: got %0b want 1", up_ready); bad++; end
    total++;
    if (down_valid !== 1'b0) begin $display("FAIL basic_valid_drop: got %0b want 0", down_valid); bad++; end
    total++;
  endtask

  task automatic test_pos_clamp();
    frame(4'h7, 4'h7, 4'hD, 4'h0);
    if (down_data !== 4'h4) begin $display("FAIL pos_clamp_data: got %h want 4", down_data); bad++; end
    total++;
    if (down_sat !== 1'b1) begin $display("FAIL pos_clamp_sat: got %0b want 1", down_sat); bad++; end
    total++;
    frame(4'h1, 4'h1, 4'h1, 4'h1);
    if (down_data !== 4'h4) begin $display("FAIL flag_clear_data: got %h want 4", down_data); bad++; end
    total++;
    if (down_sat !== 1'b0) begin $display("FAIL flag_clear_sat: got %0b want 0", down_sat); bad++; end
    total++;
  endtask

  task automatic test_neg_clamp();
    frame(4'h8, 4'hF, 4'h0, 4'h0);
    if (down_data !== 4'h8) begin $display("FAIL neg_clamp_data: got %h want 8", down_data); bad++; end
    total++;
    if (down_sat !== 1'b1) begin $display("FAIL neg_clamp_sat: got %0b want 1", down_sat); bad++; end
    total++;
    frame(4'h8, 4'h7, 4'h0, 4'h0);
    if (down_data !== 4'hF) begin $display("FAIL mixed_data: got %h want f", down_data); bad++; end
    total++;
    if (down_sat !== 1'b0) begin $display("FAIL mixed_sat: got %0b want 0", down_sat); bad++; end
    total++;
    frame(4'h7, 4'h0, 4'h0, 4'h0);
    if (down_data !== 4'h7) begin $display("FAIL pos_limit_data: got %h want 7", down_data); bad++; end
    total++;
    if (down_sat !== 1'b0) begin $display("FAIL pos_limit_sat: got %0b want 0", down_sat); bad++; end
    total++;
    frame(4'h8, 4'h0, 4'h0, 4'h0);
    if (down_data !== 4'h8) begin $display("FAIL neg_limit_data: got %h want 8", down_data); bad++; end
    total++;
    if (down_sat !== 1'b0) begin $display("FAIL neg_limit_sat: got %0b want 0", down_sat); bad++; end
    total++;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    down_ready = 1'b0;
    frame(4'h1, 4'h1, 4'h1, 4'h1);
    up_valid = 1'b1;
    up_data  = 4'h2;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (down_valid !== 1'b1) begin $display("FAIL bp_valid[%0d]: got %0b want 1", i, down_valid); bad++; end
      total++;
      if (down_data !== 4'h4) begin $display("FAIL bp_data[%0d]: got %h want 4", i, down_data); bad++; end
      total++;
      if (up_ready !== 1'b0) begin $display("FAIL bp_up_ready[%0d]: got %0b want 0", i, up_ready); bad++; end
      total++;
    end
    down_ready = 1'b1;
    // The held 2 becomes the first sample of the next frame: 2+1+1+1.
    beat(4'h2);
    beat(4'h1);
    beat(4'h1);
    beat(4'h1);
    idle();
    if (down_data !== 4'h5) begin $display("FAIL bp_next_data: got %h want 5", down_data); bad++; end
    total++;
    if (down_sat !== 1'b0) begin $display("FAIL bp_next_sat: got %0b want 0", down_sat); bad++; end
    total++;
  endtask

  task automatic test_gapped();
    beat(4'h2);
    idle();
    idle();
    beat(4'h2);
    idle();
    if (down_valid !== 1'b0) begin $display("FAIL gap_early_valid: got %0b want 0", down_valid); bad++; end
    total++;
    beat(4'h2);
    beat(4'h2);
    idle();
    if (down_valid !== 1'b1) begin $display("FAIL gap_valid: got %0b want 1", down_valid); bad++; end
    total++;
    if (down_data !== 4'h7) begin $display("FAIL gap_data: got %h want 7", down_data); bad++; end
    total++;
    if (down_sat !== 1'b1) begin $display("FAIL gap_sat: got %0b want 1", down_sat); bad++; end
    total++;
    repeat (3) @(negedge clk);
    if (down_valid !== 1'b0) begin $display("FAIL gap_extra_valid: got %0b want 0", down_valid); bad++; end
    total++;
  endtask

  task automatic test_async_reset();
    beat(4'h1);
    beat(4'h1);
    @(negedge clk);
    up_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    if (up_ready !== 1'b1) begin $display("FAIL arst_up_ready: got %0b want 1", up_ready); bad++; end
    total++;
    if (down_valid !== 1'b0) begin $display("FAIL arst_down_valid: got %0b want 0", down_valid); bad++; end
    total++;
    if (down_data !== 4'h0) begin $display("FAIL arst_down_data: got %h want 0", down_data); bad++; end
    total++;
    if (down_sat !== 1'b0) begin $display("FAIL arst_down_sat: got %0b want 0", down_sat); bad++; end
    total++;
    @(negedge clk);
    rst = 1'b0;
    frame(4'h1, 4'h1, 4'h1, 4'h1);
    if (down_valid !== 1'b1) begin $display("FAIL arst_frame_valid: got %0b want 1", down_valid); bad++; end
    total++;
    if (down_data !== 4'h4) begin $display("FAIL arst_frame_data: got %h want 4", down_data); bad++; end
    total++;
    if (down_sat !== 1'b0) begin $display("FAIL arst_frame_sat: got %0b want 0", down_sat); bad++; end
    total++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pos_clamp();
    test_neg_clamp();
    test_backpressure();
    test_gapped();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
